// File: rtl/bo_datapath.sv
// Operative datapath: X/H/S working registers fed by a one-stage pipelined ALU.
// The ALU result is registered into P every cycle; LH/LS commit P, LX loads the external operand.
module bo_datapath #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned K0    = 3,
    parameter int unsigned K1    = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] x_in,
    input  logic             LX,
    input  logic             LH,
    input  logic             LS,
    input  logic             Hula,
    input  logic [1:0]       M0,
    input  logic [1:0]       M1,
    input  logic [1:0]       M2,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             ovf
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] x_q, h_q, s_q, p_q;
    logic             p_ovf_q, ovf_q, y_valid_q;

    logic [WIDTH-1:0] op_a, op_b, alu_res;
    logic             alu_ovf;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [PW-1:0]    prod;

    // Operand A select
    always_comb begin
        op_a = x_q;
        unique case (M0)
            2'd0: op_a = x_q;
            2'd1: op_a = h_q;
            2'd2: op_a = s_q;
            2'd3: op_a = WIDTH'(K0);
            default: op_a = x_q;
        endcase
    end

    // Operand B select
    always_comb begin
        op_b = s_q;
        unique case (M1)
            2'd0: op_b = s_q;
            2'd1: op_b = x_q;
            2'd2: op_b = WIDTH'(K1);
            2'd3: op_b = h_q;
            default: op_b = s_q;
        endcase
    end

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = op_a - op_b;
    assign prod = PW'(op_a) * PW'(op_b);

    // ALU result and overflow; M2 is ignored for the multiply class
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        if (Hula) begin
            alu_res = prod[WIDTH-1:0];
            alu_ovf = |prod[PW-1:WIDTH];
        end else begin
            unique case (M2)
                2'd0: begin
                    alu_res = sum[WIDTH-1:0];
                    alu_ovf = sum[WIDTH];
                end
                2'd1: alu_res = op_a;
                2'd2: alu_res = op_b;
                2'd3: begin
                    alu_res = diff;
                    alu_ovf = (op_a < op_b);
                end
                default: alu_res = '0;
            endcase
        end
    end

    // Pipeline register, working registers and status; overflow set beats LX clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q       <= '0;
            h_q       <= '0;
            s_q       <= '0;
            p_q       <= '0;
            p_ovf_q   <= 1'b0;
            ovf_q     <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            p_q       <= alu_res;
            p_ovf_q   <= alu_ovf;
            y_valid_q <= LS;
            if (LX) x_q <= x_in;
            if (LH) h_q <= p_q;
            if (LS) s_q <= p_q;
            if ((LH || LS) && p_ovf_q) ovf_q <= 1'b1;
            else if (LX)               ovf_q <= 1'b0;
        end
    end

    assign y       = s_q;
    assign y_valid = y_valid_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bo_datapath.sv
// Testbench for bo_datapath: directed scenarios plus random control words,
// all checked against an arithmetic model of the X/H/S/P registers.
module tb_bo_datapath;

    localparam int unsigned WIDTH = 16;
    localparam int          MODV  = 65536;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] x_in = '0;
    logic             LX = 1'b0, LH = 1'b0, LS = 1'b0, Hula = 1'b0;
    logic [1:0]       M0 = '0, M1 = '0, M2 = '0;
    logic [WIDTH-1:0] y;
    logic             y_valid, ovf;

    int total = 0;
    int bad   = 0;

    // model state
    int m_x, m_h, m_s, m_p, m_povf, m_ovf, m_yv;

    bo_datapath #(.WIDTH(WIDTH), .K0(3), .K1(5)) dut (
        .clk(clk), .reset_n(reset_n), .x_in(x_in),
        .LX(LX), .LH(LH), .LS(LS), .Hula(Hula),
        .M0(M0), .M1(M1), .M2(M2),
        .y(y), .y_valid(y_valid), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_x = 0; m_h = 0; m_s = 0; m_p = 0; m_povf = 0; m_ovf = 0; m_yv = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".y"}, 32'(y), 32'(m_s));
        check({tag, ".y_valid"}, 32'(y_valid), 32'(m_yv));
        check({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    endtask

    // One control word for one edge; entered and left at a falling edge
    task automatic step(input bit lx, input bit lh, input bit ls, input bit hula,
                        input int m0, input int m1, input int m2, input int xin,
                        input string tag);
        int a, b, r, o;
        longint pr;
        LX = lx; LH = lh; LS = ls; Hula = hula;
        M0 = 2'(m0); M1 = 2'(m1); M2 = 2'(m2); x_in = 16'(xin);
        case (m0)
            0: a = m_x;
            1: a = m_h;
            2: a = m_s;
            default: a = 3;
        endcase
        case (m1)
            0: b = m_s;
            1: b = m_x;
            2: b = 5;
            default: b = m_h;
        endcase
        r = 0; o = 0;
        if (hula) begin
            pr = longint'(a) * longint'(b);
            r  = int'(pr % MODV);
            o  = (pr >= MODV) ? 1 : 0;
        end else begin
            case (m2)
                0: begin r = (a + b) % MODV; o = (a + b >= MODV) ? 1 : 0; end
                1: r = a;
                2: r = b;
                default: begin r = (a - b + MODV) % MODV; o = (a < b) ? 1 : 0; end
            endcase
        end
        @(posedge clk);
        if ((lh || ls) && m_povf != 0) m_ovf = 1;
        else if (lx)                   m_ovf = 0;
        if (lh) m_h = m_p;
        if (ls) m_s = m_p;
        if (lx) m_x = xin % MODV;
        m_yv   = ls ? 1 : 0;
        m_p    = r;
        m_povf = o;
        @(negedge clk);
        check_outputs(tag);
    endtask

    // Asserts reset between edges and checks it acts without a clock
    task automatic apply_reset(input string tag);
        #2;
        reset_n = 1'b0;
        LX = 0; LH = 0; LS = 0;
        model_clear();
        #1;
        check({tag, ".async.y"}, 32'(y), 32'd0);
        check({tag, ".async.y_valid"}, 32'(y_valid), 32'd0);
        check({tag, ".async.ovf"}, 32'(ovf), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_outputs({tag, ".held"});
        reset_n = 1'b1;
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        check_outputs("por");
        reset_n = 1'b1;

        // leave some state behind, then reset mid-cycle
        step(1, 0, 0, 0, 0, 2, 0, 16'h1234, "pre");
        step(0, 0, 1, 0, 0, 2, 0, 0, "pre");
        step(0, 1, 1, 0, 0, 2, 0, 0, "pre");
        apply_reset("rst1");

        // add: X=7, H = 7+5
        step(1, 0, 0, 0, 0, 2, 0, 7, "add.lx");
        step(0, 0, 0, 0, 0, 2, 0, 0, "add.c1");
        step(0, 1, 0, 0, 0, 2, 0, 0, "add.lh");
        check("add.ovf", 32'(ovf), 32'd0);
        // multiply: S = H*X = 84
        step(0, 0, 0, 1, 1, 1, 0, 0, "mul.c1");
        step(0, 0, 1, 1, 1, 1, 0, 0, "mul.ls");
        check("mul.y", 32'(y), 32'd84);
        check("mul.y_valid", 32'(y_valid), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, "mul.after");
        check("mul.y_valid_drop", 32'(y_valid), 32'd0);
        // H visible through S via pass A
        step(0, 0, 0, 0, 1, 0, 1, 0, "passh.c1");
        step(0, 0, 1, 0, 1, 0, 1, 0, "passh.ls");
        check("add.h", 32'(y), 32'd12);

        // add overflow into H, then LX clears ovf
        step(1, 0, 0, 0, 0, 1, 0, 16'h8000, "aovf.lx");
        step(0, 0, 0, 0, 0, 1, 0, 0, "aovf.c1");
        step(0, 1, 0, 0, 0, 1, 0, 0, "aovf.lh");
        check("aovf.ovf", 32'(ovf), 32'd1);
        step(1, 0, 0, 0, 0, 0, 1, 7, "aovf.clr");
        check("aovf.cleared", 32'(ovf), 32'd0);

        // subtract: 7-5 = 2, then 3-5 borrows
        step(0, 0, 0, 0, 0, 2, 3, 0, "sub.c1");
        step(0, 0, 1, 0, 0, 2, 3, 0, "sub.ls");
        check("sub.y", 32'(y), 32'd2);
        check("sub.ovf", 32'(ovf), 32'd0);
        step(1, 0, 0, 0, 0, 2, 3, 3, "bor.lx");
        step(0, 0, 0, 0, 0, 2, 3, 0, "bor.c1");
        step(0, 0, 1, 0, 0, 2, 3, 0, "bor.ls");
        check("bor.y", 32'(y), 32'hFFFE);
        check("bor.ovf", 32'(ovf), 32'd1);

        // LH and LS together with P = 0x0010
        step(1, 0, 0, 0, 0, 0, 1, 16'h0010, "sim.lx");
        check("sim.ovf_clr", 32'(ovf), 32'd0);
        step(0, 0, 0, 0, 0, 0, 1, 0, "sim.c1");
        step(0, 1, 1, 0, 0, 0, 1, 0, "sim.lhls");
        check("sim.s", 32'(y), 32'h0010);
        step(0, 0, 0, 0, 1, 0, 1, 0, "sim.ph1");
        step(0, 0, 1, 0, 1, 0, 1, 0, "sim.ph2");
        check("sim.h", 32'(y), 32'h0010);
        // LX and LS with p_ovf=1 on the same edge: set wins
        step(1, 0, 0, 0, 0, 2, 3, 3, "sw.lx");
        step(0, 0, 0, 0, 0, 2, 3, 0, "sw.c1");
        step(1, 0, 1, 0, 0, 2, 3, 9, "sw.lxls");
        check("sw.ovf", 32'(ovf), 32'd1);

        // random control words
        for (int i = 0; i < 600; i++) begin
            int xv;
            xv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : int'($urandom_range(0, 65535));
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), xv, "rnd");
            if (i == 300) apply_reset("rst2");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bo_datapath.md
# bo_datapath

Operative datapath driven by the project's control-word sequencer. It consumes the sequencer's registered control outputs and holds the working registers X, H and S. It runs a one-stage pipelined ALU (add, subtract, multiply, pass-through) and presents the S result with a valid pulse and a sticky overflow flag. It is the consumer side of the LX/LS/LH/Hula/M0/M1/M2 control interface.

## Interface
- WIDTH, 16, datapath width in bits
- K0, 3, constant operand selectable on ALU input A
- K1, 5, constant operand selectable on ALU input B

- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- x_in  input  WIDTH  external operand, loaded into X
- LX  input  1  load X from x_in
- LH  input  1  load H from pipeline register P
- LS  input  1  load S from pipeline register P
- Hula  input  1  ALU class: 0 = add/sub/pass, 1 = multiply
- M0  input  2  operand A select: 0 X, 1 H, 2 S, 3 K0
- M1  input  2  operand B select: 0 S, 1 X, 2 K1, 3 H
- M2  input  2  op modifier (Hula=0): 0 A+B, 1 pass A, 2 pass B, 3 A−B; ignored when Hula=1
- y  output  WIDTH  current S register
- y_valid  output  1  one-cycle pulse after S is written
- ovf  output  1  sticky overflow of any value written to H or S

## Operation
- Registers: X, H, S, P (WIDTH each), p_ovf, ovf, y_valid.
- ALU is combinational on the current A/B/Hula/M2 values.
  - Add: A+B mod 2^WIDTH; overflow = carry out.
  - Sub: A−B mod 2^WIDTH; overflow = borrow (A<B).
  - Multiply: low WIDTH bits of A*B; overflow = upper WIDTH bits nonzero.
  - Pass A or pass B: overflow = 0.
- Every clock: P <= ALU result, p_ovf <= ALU overflow. P is unconditional and has no enable.
- LX: X <= x_in, and ovf <= 0.
- LH: H <= P. LS: S <= P.
- ovf <= 1 if (LH or LS) and p_ovf.
- If LX coincides with LH/LS carrying p_ovf, set wins over clear.
- LH and LS together: both registers load the same P. LX is independent of LH/LS; all asserted loads happen on the same edge.
- Operands read pre-edge register values. A load of H whose operands also select H uses the old H.
- y_valid <= LS, so it is high exactly in the cycle after the S update.
- Control inputs come registered from the sequencer. No handshake and no stall; each control word applies to exactly one edge.

## Timing
- reset_n low, asynchronously: X, H, S, P, p_ovf, ovf, y_valid = 0 immediately, so y = 0. They stay 0 while reset_n is low.
- Reset mid-sequence discards all partial results. The first edge after reset_n rises loads P from the operands present then.
- ALU latency is 1 cycle. The value written by LH/LS at edge t is computed from the selects and registers present before edge t−1.
- The sequencer therefore holds M0/M1/M2/Hula for two consecutive cycles, asserting LH/LS in the second.
- LX latency: X is visible on operand A/B one cycle after the load edge.
- y follows S with zero added latency. y_valid is 1 cycle wide per LS cycle; back-to-back LS gives a continuous y_valid.
- Wrap-around is always mod 2^WIDTH. No saturation.

## Test plan
- Reset: run arbitrary loads, pull reset_n low between clock edges -> all registers, y, y_valid, ovf read 0 before the next edge. They remain 0 until release.
- Add: x_in=7 with LX. Then 2 cycles of M0=0, M1=2, Hula=0, M2=0, with LH in the 2nd -> H=12, ovf=0.
- Multiply: continue with M0=1, M1=1, Hula=1 for 2 cycles, LS in the 2nd -> S=84, y=84, y_valid high for exactly the next cycle.
- Add overflow: x_in=0x8000 with LX. Then M0=0, M1=1, Hula=0, M2=0, LH -> H=0x0000, ovf=1. Next LX -> ovf=0.
- Subtract/borrow: X=7, M0=0, M1=2, M2=3, LS -> S=2, ovf=0. With X=3, same word -> S=0xFFFE, ovf=1.
- Simultaneous: LH and LS in the same cycle with P=0x0010 -> H=S=0x0010. LX + LS with p_ovf=1 on one edge -> ovf=1.
